// File: rtl/tron_types_pkg.sv
// Shared types for the tron design: framebuffer geometry, pixel codes and
// the 12-bit colour palette used by the VGA scanout.
package tron_types;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        P1     = 2'b01,
        P2     = 2'b10,
        BORDER = 2'b11
    } pixel_t;

    localparam int unsigned FB_W    = 320;
    localparam int unsigned FB_H    = 240;
    localparam int unsigned FB_SIZE = FB_W * FB_H;
    localparam int unsigned FB_AW   = 19;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t PAL_EMPTY  = 12'h000;
    localparam rgb_t PAL_P1     = 12'h0F0;
    localparam rgb_t PAL_P2     = 12'hF0F;
    localparam rgb_t PAL_BORDER = 12'hFFF;

    // Map a framebuffer code to its display colour.
    function automatic rgb_t palette(input pixel_t code);
        rgb_t c;
        c = PAL_EMPTY;
        case (code)
            EMPTY:   c = PAL_EMPTY;
            P1:      c = PAL_P1;
            P2:      c = PAL_P2;
            BORDER:  c = PAL_BORDER;
            default: c = PAL_EMPTY;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing: pixel-enable divider, horizontal/vertical counters,
// raw (undelayed) active/sync flags and the per-frame strobe.
// Ports:
//   clock, reset       - system clock, synchronous active-high reset
//   pix_en_c           - one-clock pixel enable, every CLK_DIV clocks
//   hc, vc             - current raster position (registered)
//   active_c           - position lies in the visible area
//   hs_raw_c, vs_raw_c - active-low syncs for the current position
//   frame_start_c      - high in the clock the counters wrap to (0,0)
module vga_timing
    import tron_types::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HC_W    = $clog2(H_TOTAL),
    localparam int unsigned VC_W    = $clog2(V_TOTAL),
    localparam int unsigned DIV_W   = $clog2(CLK_DIV)
) (
    input  logic            clock,
    input  logic            reset,
    output logic            pix_en_c,
    output logic [HC_W-1:0] hc,
    output logic [VC_W-1:0] vc,
    output logic            active_c,
    output logic            hs_raw_c,
    output logic            vs_raw_c,
    output logic            frame_start_c
);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("vga_timing: CLK_DIV must be >= 2");
    end

    logic [DIV_W-1:0] pix_div_q, pix_div_d;
    logic [HC_W-1:0]  hc_q, hc_d;
    logic [VC_W-1:0]  vc_q, vc_d;
    logic             h_last, v_last;

    // Divider and raster counters.
    always_comb begin
        pix_en_c  = (pix_div_q == DIV_W'(CLK_DIV - 1));
        h_last    = (hc_q == HC_W'(H_TOTAL - 1));
        v_last    = (vc_q == VC_W'(V_TOTAL - 1));
        pix_div_d = pix_en_c ? '0 : pix_div_q + DIV_W'(1);
        hc_d      = hc_q;
        vc_d      = vc_q;
        if (pix_en_c) begin
            hc_d = h_last ? '0 : hc_q + HC_W'(1);
            if (h_last) begin
                vc_d = v_last ? '0 : vc_q + VC_W'(1);
            end
        end
    end

    // Raw flags for the current position, plus the wrap strobe.
    always_comb begin
        active_c = (hc_q < HC_W'(H_ACTIVE)) && (vc_q < VC_W'(V_ACTIVE));
        hs_raw_c = !((hc_q >= HC_W'(H_ACTIVE + H_FP)) &&
                     (hc_q <  HC_W'(H_ACTIVE + H_FP + H_SYNC)));
        vs_raw_c = !((vc_q >= VC_W'(V_ACTIVE + V_FP)) &&
                     (vc_q <  VC_W'(V_ACTIVE + V_FP + V_SYNC)));
        frame_start_c = pix_en_c && h_last && v_last && !reset;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pix_div_q <= '0;
            hc_q      <= '0;
            vc_q      <= '0;
        end else begin
            pix_div_q <= pix_div_d;
            hc_q      <= hc_d;
            vc_q      <= vc_d;
        end
    end

    assign hc = hc_q;
    assign vc = vc_q;

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer scanout: reads the 320x240 2bpp framebuffer through RAM port B,
// doubles each cell 2x2 and drives 640x480 VGA with a per-frame strobe.
// Ports:
//   clock, reset      - system clock, synchronous active-high reset
//   ram_address       - read address, 320*y + x (registered)
//   ram_read_data     - pixel code returned by the RAM
//   vga_r/g/b         - 4-bit colour channels (registered)
//   vga_hs, vga_vs    - active-low syncs (registered)
//   frame_start       - one-clock pulse as the raster wraps to (0,0)
module vga_scanout
    import tron_types::*;
#(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned RAM_LATENCY = 1,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33
) (
    input  logic             clock,
    input  logic             reset,
    output logic [FB_AW-1:0] ram_address,
    input  logic [1:0]       ram_read_data,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             frame_start
);

    localparam int unsigned HC_W = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int unsigned VC_W = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

    // Read data must settle within one pixel period of the address change.
    if (RAM_LATENCY < 1 || RAM_LATENCY >= CLK_DIV) begin : g_bad_ram_latency
        $error("vga_scanout: RAM_LATENCY must be in 1..CLK_DIV-1");
    end

    logic            pix_en;
    logic [HC_W-1:0] hc;
    logic [VC_W-1:0] vc;
    logic            active;
    logic            hs_raw;
    logic            vs_raw;

    vga_timing #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clock         (clock),
        .reset         (reset),
        .pix_en_c      (pix_en),
        .hc            (hc),
        .vc            (vc),
        .active_c      (active),
        .hs_raw_c      (hs_raw),
        .vs_raw_c      (vs_raw),
        .frame_start_c (frame_start)
    );

    logic [FB_AW-1:0] ram_address_q, ram_address_d;
    logic             act_s1_q, act_s1_d;
    logic             hs_s1_q, hs_s1_d;
    logic             vs_s1_q, vs_s1_d;
    rgb_t             rgb_q, rgb_d;
    logic             hs_out_q, hs_out_d;
    logic             vs_out_q, vs_out_d;
    logic [FB_AW-1:0] cell_x, cell_y;

    // Two pixel-period pipeline: slot 0 issues the address and captures the
    // raster flags; slot 1 colours the returned code and releases the syncs,
    // so colour and sync stay aligned two pixels behind the counters.
    always_comb begin
        cell_x        = FB_AW'(hc >> 1);
        cell_y        = FB_AW'(vc >> 1);
        ram_address_d = ram_address_q;
        act_s1_d      = act_s1_q;
        hs_s1_d       = hs_s1_q;
        vs_s1_d       = vs_s1_q;
        rgb_d         = rgb_q;
        hs_out_d      = hs_out_q;
        vs_out_d      = vs_out_q;
        if (pix_en) begin
            // 320*y as (y<<8)+(y<<6); peaks at 76799, well inside 19 bits.
            ram_address_d = active ? (cell_y << 8) + (cell_y << 6) + cell_x : '0;
            act_s1_d      = active;
            hs_s1_d       = hs_raw;
            vs_s1_d       = vs_raw;
            rgb_d         = act_s1_q ? palette(pixel_t'(ram_read_data)) : PAL_EMPTY;
            hs_out_d      = hs_s1_q;
            vs_out_d      = vs_s1_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ram_address_q <= '0;
            act_s1_q      <= 1'b0;
            hs_s1_q       <= 1'b1;
            vs_s1_q       <= 1'b1;
            rgb_q         <= PAL_EMPTY;
            hs_out_q      <= 1'b1;
            vs_out_q      <= 1'b1;
        end else begin
            ram_address_q <= ram_address_d;
            act_s1_q      <= act_s1_d;
            hs_s1_q       <= hs_s1_d;
            vs_s1_q       <= vs_s1_d;
            rgb_q         <= rgb_d;
            hs_out_q      <= hs_out_d;
            vs_out_q      <= vs_out_d;
        end
    end

    assign ram_address = ram_address_q;
    assign vga_r       = rgb_q.r;
    assign vga_g       = rgb_q.g;
    assign vga_b       = rgb_q.b;
    assign vga_hs      = hs_out_q;
    assign vga_vs      = vs_out_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: two instances (CLK_DIV=2/RAM_LATENCY=1 and
// CLK_DIV=4/RAM_LATENCY=3) share a clock and reset and read identical random
// framebuffer contents. A reduced vertical raster keeps frames short. The
// expected output in every clock is computed from elapsed clocks since reset.
module tb_vga_scanout;

    localparam int HA = 640, HF = 16, HS = 96, HB = 48;
    localparam int VA = 8, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int FB_CELLS = 76800;

    logic clk;
    logic reset;

    logic [18:0] addr_a, addr_b;
    logic [1:0]  rd_a, rd_b, rd_b1, rd_b2;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic        hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;

    logic [1:0] ram [FB_CELLS];

    int n;        // clocks since the last clock that sampled reset high
    int n_checks;
    int n_pass;

    vga_scanout #(
        .CLK_DIV(2), .RAM_LATENCY(1),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) u_dut_d2 (
        .clock(clk), .reset(reset),
        .ram_address(addr_a), .ram_read_data(rd_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
        .vga_hs(hs_a), .vga_vs(vs_a), .frame_start(fs_a)
    );

    vga_scanout #(
        .CLK_DIV(4), .RAM_LATENCY(3),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) u_dut_d4 (
        .clock(clk), .reset(reset),
        .ram_address(addr_b), .ram_read_data(rd_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
        .vga_hs(hs_b), .vga_vs(vs_b), .frame_start(fs_b)
    );

    always #5 clk = ~clk;

    // Framebuffer RAM models: one clock latency and three clock latency.
    always @(posedge clk) begin
        rd_a  <= (int'(addr_a) < FB_CELLS) ? ram[addr_a] : 2'b00;
        rd_b1 <= (int'(addr_b) < FB_CELLS) ? ram[addr_b] : 2'b00;
        rd_b2 <= rd_b1;
        rd_b  <= rd_b2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h at t=%0t n=%0d", tag, obs, exp, $time, n);
        else
            n_pass++;
    endtask

    function automatic logic [11:0] colour_of(input logic [1:0] code);
        case (code)
            2'b01:   return 12'h0F0;
            2'b10:   return 12'hF0F;
            2'b11:   return 12'hFFF;
            default: return 12'h000;
        endcase
    endfunction

    function automatic bit pos_active(input int p);
        return ((p % HT) < HA) && (((p / HT) % VT) < VA);
    endfunction

    function automatic int pos_addr(input int p);
        return 320 * (((p / HT) % VT) / 2) + (p % HT) / 2;
    endfunction

    // Pixel-period count m = n / d. The address reflects position m-1, the
    // pins reflect position m-2; before that the reset values are held.
    task automatic check_dut(input int d, input string pfx, input logic [18:0] a,
                             input logic [11:0] c, input logic hs, input logic vs,
                             input logic fs);
        int m, j, hj, vj;
        logic [31:0] ea, ec, ehs, evs, efs;
        m   = n / d;
        ea  = 0;
        ec  = 0;
        ehs = 1;
        evs = 1;
        if (m >= 1 && pos_active(m - 1))
            ea = 32'(pos_addr(m - 1));
        if (m >= 2) begin
            j  = m - 2;
            hj = j % HT;
            vj = (j / HT) % VT;
            if (pos_active(j))
                ec = 32'(colour_of(ram[pos_addr(j)]));
            ehs = (hj >= HA + HF && hj < HA + HF + HS) ? 0 : 1;
            evs = (vj >= VA + VF && vj < VA + VF + VS) ? 0 : 1;
        end
        efs = ((n % d) == d - 1 && (m % FT) == FT - 1 && !reset) ? 1 : 0;
        chk({pfx, ".addr"}, 32'(a), ea);
        chk({pfx, ".rgb"},  32'(c), ec);
        chk({pfx, ".hs"},   32'(hs), ehs);
        chk({pfx, ".vs"},   32'(vs), evs);
        chk({pfx, ".fs"},   32'(fs), efs);
    endtask

    task automatic step(input logic r);
        reset = r;
        @(posedge clk);
        if (r) n = 0;
        else   n++;
        #1;
        check_dut(2, "d2", addr_a, {r_a, g_a, b_a}, hs_a, vs_a, fs_a);
        check_dut(4, "d4", addr_b, {r_b, g_b, b_b}, hs_b, vs_b, fs_b);
    endtask

    initial begin
        int run_len;
        int hold;
        clk      = 1'b0;
        reset    = 1'b1;
        n        = 0;
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < FB_CELLS; i++)
            ram[i] = 2'($urandom_range(0, 3));

        repeat (3) step(1'b1);
        run_len = int'($urandom_range(3000, 15000));
        repeat (run_len) step(1'b0);

        // Mid-frame reset of random length, then long enough for both
        // instances to wrap a full frame.
        hold = int'($urandom_range(1, 3));
        repeat (hold) step(1'b1);
        repeat (40000) step(1'b0);

        step(1'b1);
        repeat (2000) step(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
